// File: rtl/phys_reg_reclaim_unit.sv
// Commit-side producer for the physical register free list: filters retiring
// old tags, buffers them in a small FIFO and feeds the free list one per cycle.
module phys_reg_reclaim_unit #(
  parameter int RECLAIM_DEPTH  = 4,
  parameter int PHYS_REG_TAG_W = 7
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      commit_valid,
  input  logic                      commit_reg_write,
  input  logic [PHYS_REG_TAG_W-1:0] commit_old_phys_reg_tag,
  output logic                      commit_ready,
  output logic                      enqueue_valid,
  output logic [PHYS_REG_TAG_W-1:0] enqueue_phys_reg_tag,
  input  logic                      free_list_full,
  input  logic                      drain_req,
  output logic                      drained,
  output logic                      overflow_error,
  output logic [31:0]               reclaim_count,
  output logic [1:0]                dbg_state
);

  localparam int IDX_W = $clog2(RECLAIM_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic [PHYS_REG_TAG_W-1:0] mem_q [RECLAIM_DEPTH];
  logic [PHYS_REG_TAG_W-1:0] mem_d [RECLAIM_DEPTH];
  logic                      overflow_q, overflow_d;
  logic [31:0]               count_q, count_d;

  logic             empty, full, push, pop, last_pop;
  logic [PTR_W-1:0] occupancy;

  // Handshakes: a commit transfers when commit_valid & commit_ready; a tag
  // transfers to the free list whenever enqueue_valid is high (the free list
  // has no separate ready, only free_list_full which gates enqueue_valid).
  assign empty        = (head_q == tail_q);
  assign full         = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                        (head_q[IDX_W] != tail_q[IDX_W]);
  assign occupancy    = tail_q - head_q;
  assign commit_ready = ~full & (state_q == ST_RUN);
  assign push         = commit_valid & commit_ready & commit_reg_write &
                        (commit_old_phys_reg_tag != '0);
  assign pop          = ~empty & ~free_list_full;
  assign last_pop     = pop && (occupancy == PTR_W'(1));

  assign enqueue_valid        = pop;
  assign enqueue_phys_reg_tag = mem_q[head_q[IDX_W-1:0]];
  assign drained              = (state_q == ST_DRAINED);
  assign overflow_error       = overflow_q;
  assign reclaim_count        = count_q;
  assign dbg_state            = state_q;

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (commit_valid & ~commit_ready);
    if (push) begin
      mem_d[tail_q[IDX_W-1:0]] = commit_old_phys_reg_tag;
      tail_d                   = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d  = head_q + PTR_W'(1);
      count_d = count_q + 32'd1;
    end
  end

  // Intake is already stopped in DRAIN, so the pop alone decides emptiness.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req)              state_d = ST_RUN;
        else if (empty || last_pop)  state_d = ST_DRAINED;
      end
      ST_DRAINED: if (!drain_req) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_RUN;
      head_q     <= '0;
      tail_q     <= '0;
      mem_q      <= '{default: '0};
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      mem_q      <= mem_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: doc/phys_reg_reclaim_unit.md
# phys_reg_reclaim_unit

Commit-side producer for the physical register free list. Accepts the committing instruction's old physical register tag from the ROB retire port, filters out non-reclaimable tags, buffers them in a small FIFO, and enqueues one tag per cycle into the free list, stalling while the free list is full. It also provides a drain handshake used at halt and before checkpoint-free restore sequences.

## Interface
- RECLAIM_DEPTH, 4: entries in the internal reclaim FIFO; power of two, at least 2.
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset, asynchronous and active-low.
- commit_valid  input  1  ROB retires one instruction this cycle.
- commit_reg_write  input  1  the retiring instruction wrote a register.
- commit_old_phys_reg_tag  input  phys_reg_tag_t  previous mapping of the destination; this tag is freed.
- commit_ready  output  1  unit can accept a commit this cycle.
- enqueue_valid  output  1  drives the free list enqueue_valid.
- enqueue_phys_reg_tag  output  phys_reg_tag_t  drives the free list enqueue_phys_reg_tag.
- free_list_full  input  1  free list full flag; blocks enqueue.
- drain_req  input  1  level request to stop accepting and empty the buffer.
- drained  output  1  buffer empty and intake stopped under drain_req.
- overflow_error  output  1  sticky; commit_valid seen while commit_ready = 0.
- reclaim_count  output  32  count of tags delivered to the free list; wraps modulo 2^32.

## Operation
- Reclaimable commit: commit_valid & commit_ready & commit_reg_write & (commit_old_phys_reg_tag != 0). Tag 0 is the permanently mapped zero register and is never freed. Non-reclaimable commits are accepted and dropped.
- FIFO: head/tail pointers are {index, msb}, sized log2(RECLAIM_DEPTH)+1. Empty when the pointers are equal. Full when the indices are equal and the msbs differ. Wrap is by natural index overflow.
- Push: a reclaimable commit writes the tag at tail, and tail increments.
- Pop: enqueue_valid = ~empty & ~free_list_full. enqueue_phys_reg_tag = entry[head], driven combinationally even when enqueue_valid = 0. When enqueue_valid is high, head increments and reclaim_count increments by 1.
- A push and a pop may occur in the same cycle; occupancy is unchanged.
- commit_ready = ~full & (state == RUN).
- overflow_error sets when commit_valid & ~commit_ready. It clears only on reset. The offending commit is dropped.
- State machine:
  - RUN: go to DRAIN when drain_req = 1.
  - DRAIN: intake is stopped and pops continue. Go to DRAINED when the FIFO is empty, or will be empty after this cycle's pop. Go to RUN if drain_req drops.
  - DRAINED: drained = 1. Go to RUN when drain_req drops.
- drained = (state == DRAINED). It is registered and never high while the FIFO holds entries.

## Timing
- Reset values: FIFO empty, state RUN, enqueue_valid 0, enqueue_phys_reg_tag = entry[0] (don't-care), commit_ready 1, drained 0, overflow_error 0, reclaim_count 0.
- Latency: a commit accepted in cycle N is visible on enqueue_valid in cycle N+1 at the earliest. There is no same-cycle bypass.
- Throughput: 1 tag per cycle while free_list_full = 0.
- free_list_full is sampled combinationally. While it stays high, FIFO contents and head are frozen.
- drain_req asserted in cycle N:
  - commit_ready falls in cycle N+1.
  - drained rises in the cycle after the last pop.
  - With an empty FIFO, drained rises in cycle N+2.
- Reset mid-operation discards all buffered tags. The free list resets itself to full, so no tags leak.

## Test plan
- Reset, then commit tags 33, 34, 35 on consecutive cycles with reg_write = 1 -> enqueue_valid high in cycles 2–4 with tags 33, 34, 35; reclaim_count = 3.
- Commits with reg_write = 0 (tag 40) and with tag 0 (reg_write = 1) -> no enqueue_valid; reclaim_count unchanged.
- free_list_full = 1, then 5 reclaimable commits (tags 50–54) with depth 4:
  - commit_ready falls after 4 accepts.
  - The 5th commit_valid sets overflow_error.
  - Release full -> tags 50, 51, 52, 53 emitted in order; 54 is absent.
- Fill to 3 entries, then push and pop simultaneously for 8 cycles across the pointer wrap -> FIFO order is preserved and occupancy stays at 3.
- 2 entries buffered, assert drain_req -> commit_ready drops the next cycle, both tags are emitted, then drained = 1. Deassert drain_req -> RUN and commit_ready = 1.
- Assert nRST low mid-stream with 3 entries buffered -> outputs go to reset values immediately (asynchronously), with no enqueue_valid after release.
